// File: rtl/div_seq_ctrl_pkg.sv
// rtl/div_seq_ctrl_pkg.sv - shared constants and state encoding for the divide sequencer
package div_seq_ctrl_pkg;

   localparam int WORD_W         = 32;
   localparam int DIV_CYCLES_DEF = 34;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } div_state_e;

endpackage

// File: rtl/sign_mag.sv
// rtl/sign_mag.sv - conditional two's-complement negate, wrap allowed
module sign_mag #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         neg,
   output logic [W-1:0] result
);

   assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - DIV sequencer: operand magnitudes, divider window, sign fix, HI/LO
module div_seq_ctrl
   import div_seq_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [WORD_W-1:0] FromA,
   input  logic [WORD_W-1:0] FromB,
   output logic              DivCtrl,
   output logic [WORD_W-1:0] DivA,
   output logic [WORD_W-1:0] DivB,
   input  logic [WORD_W-1:0] DivQuot,
   input  logic [WORD_W-1:0] DivRem,
   output logic              Busy,
   output logic              Done,
   output logic              Div0,
   output logic [WORD_W-1:0] HIOut,
   output logic [WORD_W-1:0] LOOut
);

   localparam int             CNT_W    = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

   div_state_e        state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic              sa, sb;
   logic              start_ok, div0_hit;
   logic [WORD_W-1:0] mag_a, mag_b, lo_fix, hi_fix;

   assign start_ok = (state == IDLE) && Start && (FromB != '0);
   assign div0_hit = (state == IDLE) && Start && (FromB == '0);

   // Decoded from the async-reset state so DivCtrl drops the moment Reset falls
   assign DivCtrl = (state == RUN);
   assign Busy    = (state != IDLE);

   sign_mag #(.W(WORD_W)) u_mag_a (.value(FromA),   .neg(FromA[WORD_W-1]), .result(mag_a));
   sign_mag #(.W(WORD_W)) u_mag_b (.value(FromB),   .neg(FromB[WORD_W-1]), .result(mag_b));
   sign_mag #(.W(WORD_W)) u_fix_q (.value(DivQuot), .neg(sa ^ sb),         .result(lo_fix));
   sign_mag #(.W(WORD_W)) u_fix_r (.value(DivRem),  .neg(sa),              .result(hi_fix));

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_ok) state_next = RUN;
         RUN:     if (cnt == CNT_LAST) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cnt   <= '0;
         sa    <= 1'b0;
         sb    <= 1'b0;
         DivA  <= '0;
         DivB  <= '0;
         HIOut <= '0;
         LOOut <= '0;
         Done  <= 1'b0;
         Div0  <= 1'b0;
      end else begin
         Done <= (state == FIX);
         Div0 <= div0_hit;
         if (start_ok) begin
            sa   <= FromA[WORD_W-1];
            sb   <= FromB[WORD_W-1];
            DivA <= mag_a;
            DivB <= mag_b;
            cnt  <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
         end
         // Remainder follows the dividend's sign, quotient the XOR of both
         if (state == FIX) begin
            HIOut <= hi_fix;
            LOOut <= lo_fix;
         end
      end
   end

endmodule
